// File: rtl/hs_upload_streamer.sv
// hs_upload_streamer: serves HPS uploads of one ioctl index from a game RAM window.
// On an upload of DUMP_INDEX it pauses the CPU, fetches bytes through the RAM
// side-port and returns them on ioctl_din; a save_trigger raises ioctl_upload_req.
// Ports: clk_sys, reset (async, active-high); save_trigger; ioctl_upload/rd/addr/index
// in; ioctl_din/wait/upload_req out; pause_cpu out, paused in; ram_address,
// ram_read_intent out, ram_data in; busy out (state != IDLE).
// Option: define HS_CHECKSUM_EN to return a mod-256 sum of the window at ioctl_addr==LENGTH.
module hs_upload_streamer #(
    parameter int ADDR_W      = 16,
    parameter int DUMP_INDEX  = 6,
    parameter int BASE_ADDR   = 0,
    parameter int LENGTH      = 101,
    parameter int RAM_LATENCY = 1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              save_trigger,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_index,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              ioctl_upload_req,
    output logic              pause_cpu,
    input  logic              paused,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_read_intent,
    input  logic [7:0]        ram_data,
    output logic              busy
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] HALT    = 3'd1;
    localparam logic [2:0] READY   = 3'd2;
    localparam logic [2:0] FETCH   = 3'd3;
    localparam logic [2:0] RELEASE = 3'd4;

    localparam logic [24:0]       LEN  = 25'(LENGTH);
    localparam logic [1:0]        LAT  = 2'(RAM_LATENCY);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [7:0]        IDX  = 8'(DUMP_INDEX);

    logic [2:0]  state;
    logic        active;
    logic        active_d;
    logic        rise;
    logic        pending;
    logic        save_pend;
    logic        capture;
    logic        do_serve;
    logic        in_range;
    logic [24:0] rd_addr;
    logic [24:0] sel_addr;
    logic [1:0]  cnt;
    logic [7:0]  oob_byte;

    assign active  = ioctl_upload & (ioctl_index == IDX);
    assign rise    = active & ~active_d;
    assign busy    = (state != IDLE);
    assign capture = (state == FETCH) && (cnt == LAT);

    // A read that arrived while the CPU had un-paused is parked in rd_addr
    // and replayed from HALT once paused returns.
    assign sel_addr = (state == HALT) ? rd_addr : ioctl_addr;
    assign in_range = (sel_addr < LEN);
    assign do_serve = active & paused &
                      (((state == READY) & ioctl_rd & ~ioctl_wait) |
                       ((state == HALT) & pending));

`ifdef HS_CHECKSUM_EN
    logic [7:0] sum;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sum <= 8'h00;
        end else if (rise) begin
            sum <= 8'h00;
        end else if (capture) begin
            sum <= sum + ram_data;
        end
    end

    assign oob_byte = (sel_addr == LEN) ? sum : 8'hFF;
`else
    assign oob_byte = 8'hFF;
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            active_d         <= 1'b0;
            pause_cpu        <= 1'b0;
            ioctl_wait       <= 1'b0;
            ioctl_din        <= 8'h00;
            ioctl_upload_req <= 1'b0;
            ram_address      <= '0;
            ram_read_intent  <= 1'b0;
            save_pend        <= 1'b0;
            pending          <= 1'b0;
            rd_addr          <= '0;
            cnt              <= '0;
        end else begin
            active_d <= active;

            // Saves requested mid-upload are deferred until RELEASE.
            if (save_trigger) begin
                if (busy) begin
                    save_pend <= 1'b1;
                end else if (!rise) begin
                    ioctl_upload_req <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (rise) begin
                        ioctl_upload_req <= 1'b0;
                        pause_cpu        <= 1'b1;
                        ioctl_wait       <= 1'b1;
                        state            <= HALT;
                    end
                end
                HALT: begin
                    if (!active) begin
                        pause_cpu  <= 1'b0;
                        ioctl_wait <= 1'b0;
                        pending    <= 1'b0;
                        state      <= RELEASE;
                    end else if (paused) begin
                        if (pending) begin
                            pending <= 1'b0;
                        end else begin
                            ioctl_wait <= 1'b0;
                            state      <= READY;
                        end
                    end
                end
                READY: begin
                    if (!active) begin
                        pause_cpu  <= 1'b0;
                        ioctl_wait <= 1'b0;
                        state      <= RELEASE;
                    end else if (!paused) begin
                        ioctl_wait <= 1'b1;
                        state      <= HALT;
                        if (ioctl_rd) begin
                            pending <= 1'b1;
                            rd_addr <= ioctl_addr;
                        end
                    end
                end
                FETCH: begin
                    if (capture) begin
                        ioctl_din       <= ram_data;
                        ram_read_intent <= 1'b0;
                        ioctl_wait      <= 1'b0;
                        if (!active) begin
                            pause_cpu <= 1'b0;
                            state     <= RELEASE;
                        end else begin
                            state <= READY;
                        end
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                RELEASE: begin
                    if (save_pend || save_trigger) begin
                        ioctl_upload_req <= 1'b1;
                    end
                    save_pend <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (do_serve) begin
                if (in_range) begin
                    ioctl_wait      <= 1'b1;
                    ram_address     <= BASE + sel_addr[ADDR_W-1:0];
                    ram_read_intent <= 1'b1;
                    cnt             <= '0;
                    state           <= FETCH;
                end else begin
                    ioctl_din  <= oob_byte;
                    ioctl_wait <= 1'b0;
                    state      <= READY;
                end
            end
        end
    end

endmodule
